// File: rtl/flash_ctrl_wb.sv
// flash_ctrl_wb
//   Wishbone read-only slave that fetches 32-bit words from a parallel NOR
//   flash of FLASH_DW bits, one beat at a time, each beat lasting
//   WAIT_CYC+1 clocks. Beats are assembled big-endian (beat 0 in the top
//   lane). Writes are rejected with a one-cycle wb_err_o.
//
//   Optional feature: define FLASH_PREFETCH_EN to add a one-word read buffer
//   (valid, tag, data). A tag hit is answered on the next edge without
//   touching the flash; flash_inv_i clears the buffer.
//
// Ports
//   wb_clk_i, wb_rst_i        clock; asynchronous active-low reset
//   wb_adr_i .. wb_cyc_i      Wishbone slave inputs (wb_dat_i, wb_sel_i unused)
//   wb_dat_o, wb_ack_o,       read data, read completion, write rejection
//   wb_err_o
//   flash_adr_o, flash_dat_i  flash byte address / read data
//   flash_ce_n, flash_oe_n,   active-low flash strobes
//   flash_we_n, flash_rst_n
//   flash_inv_i               prefetch-buffer invalidate pulse
//   dbg_state                 current FSM state (IDLE=0, BEAT=1, ACK=2, ERR=3)
//
// Handshake: a request is wb_cyc_i & wb_stb_i sampled in IDLE. The master
// holds it until wb_ack_o or wb_err_o is seen; both are single-cycle pulses
// and the next request is only taken in the following IDLE cycle. Dropping
// wb_cyc_i during a flash access aborts it without an ack.
module flash_ctrl_wb #(
  parameter int ADR_W    = 22,
  parameter int FLASH_DW = 8,
  parameter int WAIT_CYC = 3
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [ADR_W-1:0]    flash_adr_o,
  input  logic [FLASH_DW-1:0] flash_dat_i,
  output logic                flash_ce_n,
  output logic                flash_oe_n,
  output logic                flash_we_n,
  output logic                flash_rst_n,
  input  logic                flash_inv_i,
  output logic [1:0]          dbg_state
);

  localparam int         BEATS      = 32 / FLASH_DW;
  localparam int         SW         = 32 - FLASH_DW;  // staging width
  localparam logic [1:0] LAST_BEAT  = 2'(BEATS - 1);
  localparam logic [1:0] BEAT_BYTES = 2'(FLASH_DW / 8);
  localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYC);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, ACK = 2'd2, ERR = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt;
  logic [1:0]    beat;
  logic [SW-1:0] stage;
  logic [1:0]    nxt_off;
  logic          req, hit, start, take_hit, sample, last_sample;
  logic [31:0]   hit_data;
  logic [31:0]   full_word;

  assign req         = wb_cyc_i & wb_stb_i;
  assign start       = (state_q == IDLE) & req & ~wb_we_i & ~hit;
  assign take_hit    = (state_q == IDLE) & req & ~wb_we_i & hit;
  assign sample      = (state_q == BEAT) & wb_cyc_i & (cnt == WAIT_LAST);
  assign last_sample = sample & (beat == LAST_BEAT);
  // Earlier beats sit in the staging register; the last beat completes the word.
  assign full_word   = {stage, flash_dat_i};
  // Byte offset of the next beat; wraps to 0 after the last beat.
  assign nxt_off     = (beat + 2'd1) * BEAT_BYTES;

`ifdef FLASH_PREFETCH_EN
  logic             pf_valid;
  logic [ADR_W-3:0] pf_tag;
  logic [31:0]      pf_data;

  // An invalidate in the same cycle as a lookup forces the flash path.
  assign hit      = pf_valid & ~flash_inv_i & (pf_tag == wb_adr_i[ADR_W-1:2]);
  assign hit_data = pf_data;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      pf_valid <= 1'b0;
      pf_tag   <= '0;
      pf_data  <= '0;
    end else if (flash_inv_i) begin
      // Invalidate also beats a load completing in the same cycle: the
      // flash contents may have changed under the access.
      pf_valid <= 1'b0;
    end else if (last_sample) begin
      pf_valid <= 1'b1;
      pf_tag   <= flash_adr_o[ADR_W-1:2];
      pf_data  <= full_word;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = flash_inv_i;
  assign hit        = 1'b0;
  assign hit_data   = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADR_W], wb_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (wb_we_i)  state_d = ERR;
          else if (hit) state_d = ACK;
          else          state_d = BEAT;
        end
      end
      BEAT: begin
        if (!wb_cyc_i)        state_d = IDLE;
        else if (last_sample) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cnt         <= '0;
      beat        <= '0;
      stage       <= '0;
      flash_adr_o <= '0;
      wb_dat_o    <= '0;
    end else if (start) begin
      cnt         <= '0;
      beat        <= '0;
      flash_adr_o <= {wb_adr_i[ADR_W-1:2], 2'b00};
    end else if (take_hit) begin
      wb_dat_o <= hit_data;
    end else if ((state_q == BEAT) && wb_cyc_i) begin
      if (sample) begin
        cnt         <= '0;
        beat        <= beat + 2'd1;
        flash_adr_o <= {flash_adr_o[ADR_W-1:2], nxt_off};
        stage       <= SW'(full_word);
        if (last_sample) wb_dat_o <= full_word;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign wb_ack_o    = (state_q == ACK);
  assign wb_err_o    = (state_q == ERR);
  assign flash_ce_n  = (state_q != BEAT);
  assign flash_oe_n  = (state_q != BEAT);
  assign flash_we_n  = 1'b1;
  assign flash_rst_n = wb_rst_i;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_flash_ctrl_wb.sv
// Bench for flash_ctrl_wb: an 8-bit/WAIT_CYC=3 instance and a
// 16-bit/WAIT_CYC=1 instance share clock, reset and a byte-array flash.
// Latency is counted in clock edges from the edge that first samples the
// request to the edge after which ack/err is visible.
module tb_flash_ctrl_wb;

  localparam int LAT8  = 4 * (3 + 1) + 1;
  localparam int LAT16 = 2 * (1 + 1) + 1;
`ifdef FLASH_PREFETCH_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = LAT8;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic [31:0] adr8, dat8, adr16, dat16;
  logic        we8, stb8, cyc8, ack8, err8, ce8, oe8, fwe8, frst8;
  logic        we16, stb16, cyc16, ack16, err16, ce16, oe16, fwe16, frst16;
  logic [21:0] fadr8, fadr16;
  logic [7:0]  fdat8;
  logic [15:0] fdat16;
  logic [1:0]  st8, st16;
  logic        inv;

  logic [7:0] mem [0:1023];
  assign fdat8  = mem[fadr8[9:0]];
  assign fdat16 = {mem[fadr16[9:0]], mem[fadr16[9:0] + 10'd1]};

  flash_ctrl_wb #(.ADR_W(22), .FLASH_DW(8), .WAIT_CYC(3)) u_dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr8), .wb_dat_i(32'h0),
    .wb_sel_i(4'hF), .wb_we_i(we8), .wb_stb_i(stb8), .wb_cyc_i(cyc8),
    .wb_dat_o(dat8), .wb_ack_o(ack8), .wb_err_o(err8), .flash_adr_o(fadr8),
    .flash_dat_i(fdat8), .flash_ce_n(ce8), .flash_oe_n(oe8), .flash_we_n(fwe8),
    .flash_rst_n(frst8), .flash_inv_i(inv), .dbg_state(st8));

  flash_ctrl_wb #(.ADR_W(22), .FLASH_DW(16), .WAIT_CYC(1)) u_dut16 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr16), .wb_dat_i(32'h0),
    .wb_sel_i(4'hF), .wb_we_i(we16), .wb_stb_i(stb16), .wb_cyc_i(cyc16),
    .wb_dat_o(dat16), .wb_ack_o(ack16), .wb_err_o(err16), .flash_adr_o(fadr16),
    .flash_dat_i(fdat16), .flash_ce_n(ce16), .flash_oe_n(oe16), .flash_we_n(fwe16),
    .flash_rst_n(frst16), .flash_inv_i(inv), .dbg_state(st16));

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: last completed word and the one-word buffer contents.
  logic [31:0] m_last [2];
  logic        m_pv   [2];
  logic [19:0] m_tag  [2];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {mem[b], mem[b + 10'd1], mem[b + 10'd2], mem[b + 10'd3]};
  endfunction

  function automatic logic model_hit(input int w, input logic [31:0] a, input logic inv_with);
`ifdef FLASH_PREFETCH_EN
    return m_pv[w] && (m_tag[w] == a[21:2]) && !inv_with;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_update(input int w, input logic we, input logic [31:0] a, input logic inv_with);
    if (inv_with) begin
      m_pv[0] = 1'b0;
      m_pv[1] = 1'b0;
    end
    if (!we) begin
      m_last[w] = ref_word(a);
      m_pv[w]   = 1'b1;
      m_tag[w]  = a[21:2];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_last[i] = '0;
      m_pv[i]   = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic xfer(input int w, input logic we, input logic [31:0] a, input logic inv_with,
                      output logic got_ack, output logic got_err, output int lat,
                      output logic [31:0] dat, output logic ce_seen, output logic pulse_end);
    @(negedge clk);
    if (w == 0) begin cyc8 = 1; stb8 = 1; we8 = we; adr8 = a; end
    else        begin cyc16 = 1; stb16 = 1; we16 = we; adr16 = a; end
    inv = inv_with;
    lat = 0; got_ack = 0; got_err = 0; ce_seen = 0;
    while (!got_ack && !got_err && lat < 200) begin
      @(posedge clk); #1;
      inv = 1'b0;
      lat++;
      got_ack = (w == 0) ? ack8 : ack16;
      got_err = (w == 0) ? err8 : err16;
      if (((w == 0) ? ce8 : ce16) == 1'b0) ce_seen = 1'b1;
    end
    dat = (w == 0) ? dat8 : dat16;
    cyc8 = 0; stb8 = 0; we8 = 0; cyc16 = 0; stb16 = 0; we16 = 0;
    @(posedge clk); #1;
    pulse_end = (w == 0) ? !(ack8 | err8) : !(ack16 | err16);
  endtask

  task automatic check_xfer(input string name, input int w, input logic we, input logic [31:0] a,
                            input logic inv_with, input logic exp_err, input logic [31:0] exp_dat,
                            input int exp_lat);
    logic ga, ge, ce, pe;
    int lat;
    logic [31:0] d;
    xfer(w, we, a, inv_with, ga, ge, lat, d, ce, pe);
    chk({name, "_resp"}, {62'd0, ga, ge}, {62'd0, !exp_err, exp_err});
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_data"}, {32'd0, d}, {32'd0, exp_dat});
    chk({name, "_pulse1"}, {63'd0, pe}, 64'd1);
    chk({name, "_flash_used"}, {63'd0, ce}, {63'd0, (exp_lat > 1)});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_lat;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] prev [2];
    logic        we, iw, h;
    int          w, el;

    rst_n = 0; inv = 0;
    cyc8 = 0; stb8 = 0; we8 = 0; adr8 = 0;
    cyc16 = 0; stb16 = 0; we16 = 0; adr16 = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
    mem[10'h104] = 8'hDE; mem[10'h105] = 8'hAD; mem[10'h106] = 8'hBE; mem[10'h107] = 8'hEF;
    mem[10'h008] = 8'hAB; mem[10'h009] = 8'hCD; mem[10'h00A] = 8'h12; mem[10'h00B] = 8'h34;
    model_reset();

    tbl[0] = '{1'b0, 32'h0000_0100, 1'b0, 32'h1122_3344, LAT8};
    tbl[1] = '{1'b0, 32'h0000_0100, 1'b0, 32'h1122_3344, HIT_LAT};
    tbl[2] = '{1'b1, 32'h0000_0040, 1'b1, 32'h1122_3344, 1};
    tbl[3] = '{1'b0, 32'h0000_0104, 1'b0, 32'hDEAD_BEEF, LAT8};
    tbl[4] = '{1'b0, 32'h0000_0102, 1'b0, 32'h1122_3344, LAT8};
    tbl[5] = '{1'b0, 32'h0040_0102, 1'b0, 32'h1122_3344, HIT_LAT};

    // Reset state while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {58'd0, ack8, err8, ce8, oe8, fwe8, frst8}, {58'd0, 6'b001110});
    chk("rst_dat8", {32'd0, dat8}, 64'd0);
    chk("rst_adr8", {42'd0, fadr8}, 64'd0);
    chk("rst_dat16", {32'd0, dat16}, 64'd0);
    @(negedge clk); rst_n = 1;
    #1;
    chk("rst_release_frst", {62'd0, frst8, frst16}, 64'd3);

    // Table-driven sequence on the 8-bit instance
    for (int i = 0; i < 6; i++) begin
      check_xfer($sformatf("tbl%0d", i), 0, tbl[i].we, tbl[i].adr, 1'b0,
                 tbl[i].exp_err, tbl[i].exp_dat, tbl[i].exp_lat);
      model_update(0, tbl[i].we, tbl[i].adr, 1'b0);
    end

    // Invalidate pulse, then re-read goes to flash
    @(negedge clk); inv = 1; @(negedge clk); inv = 0;
    m_pv[0] = 0; m_pv[1] = 0;
    check_xfer("inv_then_read", 0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h1122_3344, LAT8);
    model_update(0, 1'b0, 32'h100, 1'b0);
    // Invalidate coincident with a would-be hit
    check_xfer("inv_with_hit", 0, 1'b0, 32'h100, 1'b1, 1'b0, 32'h1122_3344, LAT8);
    model_update(0, 1'b0, 32'h100, 1'b1);

    // 16-bit instance, WAIT_CYC=1
    check_xfer("dw16_read8", 1, 1'b0, 32'h8, 1'b0, 1'b0, 32'hABCD_1234, LAT16);
    model_update(1, 1'b0, 32'h8, 1'b0);

    // Abort after beat 1: accept at edge 1, beats sample at edges 5 and 9
    @(negedge clk); cyc8 = 1; stb8 = 1; we8 = 0; adr8 = 32'h200;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_ce_before", {63'd0, ce8}, 64'd0);
    cyc8 = 0; stb8 = 0;
    @(posedge clk); #1;
    chk("abort_ce_after", {63'd0, ce8}, 64'd1);
    begin
      logic seen;
      seen = 0;
      repeat (10) begin @(posedge clk); #1; seen |= ack8; end
      chk("abort_no_ack", {63'd0, seen}, 64'd0);
    end
    chk("abort_dat_kept", {32'd0, dat8}, {32'd0, m_last[0]});

    // Randomized transactions against the model
    prev[0] = 32'h100; prev[1] = 32'h8;
    for (int i = 0; i < 40; i++) begin
      w  = $urandom_range(0, 1);
      we = ($urandom_range(0, 4) == 0);
      iw = ($urandom_range(0, 5) == 0);
      a  = ($urandom_range(0, 2) == 0) ? prev[w] : $urandom;
      h  = model_hit(w, a, iw);
      el = we ? 1 : (h ? 1 : ((w == 0) ? LAT8 : LAT16));
      check_xfer($sformatf("rnd%0d", i), w, we, a, iw, we,
                 we ? m_last[w] : ref_word(a), el);
      model_update(w, we, a, iw);
      if (!we) prev[w] = a;
    end

    // Reset at edge 5 of a read
    @(negedge clk); cyc8 = 1; stb8 = 1; we8 = 0; adr8 = 32'h300;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 0; cyc8 = 0; stb8 = 0;
    #1;
    chk("midrst_strobes", {58'd0, ack8, err8, ce8, oe8, fwe8, frst8}, {58'd0, 6'b001110});
    chk("midrst_dat", {32'd0, dat8}, 64'd0);
    chk("midrst_adr", {42'd0, fadr8}, 64'd0);
    model_reset();
    @(negedge clk); rst_n = 1;
    begin
      logic seen;
      seen = 0;
      repeat (20) begin @(posedge clk); #1; seen |= ack8; end
      chk("midrst_no_ack", {63'd0, seen}, 64'd0);
    end
    // Buffer is empty after reset: same word goes to flash again
    check_xfer("post_rst_read", 0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h1122_3344, LAT8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/flash_ctrl_wb.md
FLASH_CTRL_WB -- requirements
Module: flash_ctrl_wb

Interface
REQ-001 SHALL have parameter ADR_W, default 22, flash byte-address width.
REQ-002 SHALL have parameter FLASH_DW, default 8, flash data width; only 8 or 16 legal; BEATS = 32/FLASH_DW.
REQ-003 SHALL have parameter WAIT_CYC, default 3, wait cycles per flash beat; range 1-15.
REQ-004 SHALL have port wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports wb_adr_i in 32 / wb_dat_i in 32 / wb_sel_i in 4 / wb_we_i in 1 / wb_stb_i in 1 / wb_cyc_i in 1: Wishbone slave inputs; wb_dat_i and wb_sel_i unused.
REQ-007 SHALL have ports wb_dat_o out 32 / wb_ack_o out 1 / wb_err_o out 1: read data, read completion, write rejection.
REQ-008 SHALL have port flash_adr_o  out  ADR_W  flash byte address.
REQ-009 SHALL have port flash_dat_i  in  FLASH_DW  flash read data.
REQ-010 SHALL have ports flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n  out  1  active-low flash strobes.
REQ-011 SHALL have port flash_inv_i  in  1  prefetch-buffer invalidate pulse.

Function
REQ-012 SHALL implement states IDLE, BEAT, ACK, ERR.
REQ-013 IDLE: request = wb_cyc_i & wb_stb_i; write request -> ERR; read request -> BEAT with beat=0, cnt=0, flash_adr_o={wb_adr_i[ADR_W-1:2],2'b00}.
REQ-014 BEAT: cnt<WAIT_CYC -> cnt+1; cnt==WAIT_CYC -> sample flash_dat_i, cnt=0, beat+1, flash_adr_o low bits = (beat+1)*FLASH_DW/8.
REQ-015 Each beat SHALL take exactly WAIT_CYC+1 cycles; wb_ack_o SHALL rise BEATS*(WAIT_CYC+1) edges after the accepting edge (8-bit, WAIT_CYC=3: 16).
REQ-016 Lanes big-endian: beat 0 -> wb_dat_o[31:32-FLASH_DW], last beat -> low lane.
REQ-017 Last-beat sample SHALL update wb_dat_o atomically (staging register) and enter ACK; wb_dat_o never shows a partial word.
REQ-018 ACK: wb_ack_o high exactly one cycle, then IDLE; new request accepted no earlier than next IDLE cycle.
REQ-019 ERR: wb_err_o high exactly one cycle, then IDLE; flash untouched; wb_dat_o unchanged.
REQ-020 wb_cyc_i low in BEAT SHALL abort: IDLE next edge, no ack, wb_dat_o unchanged.
REQ-021 flash_ce_n=0 and flash_oe_n=0 only in BEAT; otherwise 1.
REQ-022 flash_we_n SHALL be constant 1; flash_rst_n SHALL equal wb_rst_i.
REQ-023 wb_dat_o SHALL hold last completed read word between accesses.
REQ-024 wb_sel_i ignored; full word always fetched.

Reset
REQ-025 On wb_rst_i low, immediately: state IDLE, cnt=0, beat=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, flash_adr_o=0, prefetch valid=0.
REQ-026 Reset mid-access SHALL abandon the access; no ack after release.

Configuration
REQ-027 Macro FLASH_PREFETCH_EN SHALL compile in a one-word read buffer (valid bit, tag = wb_adr_i[ADR_W-1:2], data).
REQ-028 With macro: every completed read loads buffer; IDLE read with valid & tag match -> ACK next edge with buffered data, flash strobes stay high.
REQ-029 With macro: flash_inv_i high clears valid; simultaneous with a hit, invalidate wins and the read goes to flash.
REQ-030 Without macro: no buffer, every read goes to flash, flash_inv_i ignored.

Verification
REQ-031 Reset, FLASH_DW=8, WAIT_CYC=3, read 0x100, flash returns 0x11,0x22,0x33,0x44 at 0x100-0x103 -> wb_dat_o=0x11223344, ack 16 edges after accept, one cycle wide.
REQ-032 FLASH_DW=16, WAIT_CYC=1, read 0x8, flash halfwords 0xABCD@0x8, 0x1234@0xA -> wb_dat_o=0xABCD1234, ack after 4 edges.
REQ-033 Write to 0x40 -> wb_err_o one cycle next edge, wb_ack_o 0, flash_ce_n stays 1.
REQ-034 Drop wb_cyc_i after beat 1 -> no ack, flash_ce_n=1 next edge, wb_dat_o keeps previous value.
REQ-035 FLASH_PREFETCH_EN: read 0x100 twice -> second ack 1 edge after accept, flash_ce_n stays 1; pulse flash_inv_i then read 0x100 -> full 16-edge access.
REQ-036 Assert wb_rst_i low at edge 5 of a read -> all outputs reset values immediately; no ack after release.
